dma_engine: RTL and testbench

Parametrised DMA between the CNN datapath, external RAM and the filter/bias buffer. It supports four modes: window read, word write, multi-filter load, and chunked bias load. Transfers use a registered FSM with a start/busy/done handshake, address stepping, short-chunk handling on the last bias chunk, and a RAM-response timeout. It sits between the layer controller and the RAM and filter/bias (FB) modules.

---
 rtl/dma_engine_if.sv | 54 +++++
 rtl/dma_engine.sv | 205 ++++++++++++++++++++
 tb/tb_dma_engine.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_engine_if.sv
// DMA engine bus bundle: controller handshake, RAM port and filter/bias buffer port.
interface dma_engine_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned WIN    = 5,
    parameter int unsigned CNT_W  = 8
);
    localparam int unsigned N     = WIN * WIN;
    localparam int unsigned BLK_W = N * DATA_W;

    // controller side
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] address;
    logic [ADDR_W-1:0] offset;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] cnn_wr_data;
    logic [BLK_W-1:0]  cnn_rd_data;
    logic              busy;
    logic              done;
    logic              err;

    // RAM side
    logic              ram_en;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_address;
    logic [ADDR_W-1:0] ram_offset;
    logic [DATA_W-1:0] ram_wdata;
    logic [BLK_W-1:0]  ram_rdata;
    logic              ram_finish;

    // filter/bias buffer side
    logic              fb_write;
    logic              fb_bias_or_filter;
    logic [CNT_W-1:0]  fb_index;
    logic [BLK_W-1:0]  fb_data;
    logic [CNT_W-1:0]  fb_valid;

    // engine view
    modport master (
        input  start, mode, address, offset, count, cnn_wr_data, ram_rdata, ram_finish,
        output cnn_rd_data, busy, done, err,
               ram_en, ram_write, ram_address, ram_offset, ram_wdata,
               fb_write, fb_bias_or_filter, fb_index, fb_data, fb_valid
    );

    // controller / RAM / buffer view
    modport slave (
        output start, mode, address, offset, count, cnn_wr_data, ram_rdata, ram_finish,
        input  cnn_rd_data, busy, done, err,
               ram_en, ram_write, ram_address, ram_offset, ram_wdata,
               fb_write, fb_bias_or_filter, fb_index, fb_data, fb_valid
    );
endinterface

// File: rtl/dma_engine.sv
// DMA engine: window read, word write, multi-filter load and chunked bias load
// between the CNN datapath, external RAM and the filter/bias buffer.
module dma_engine #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned WIN     = 5,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    dma_engine_if.master bus
);
    localparam int unsigned N      = WIN * WIN;
    localparam int unsigned BLK_W  = N * DATA_W;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned BASE_W = CNT_W + $clog2(N) + 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;
    typedef enum logic [1:0] {M_RD, M_WR, M_FILT, M_BIAS} mode_t;

    state_t             state, state_n;
    mode_t              mode_q, mode_n;
    logic [ADDR_W-1:0]  inner_addr, inner_n;
    logic [CNT_W-1:0]   count_q, count_n;
    logic [CNT_W-1:0]   idx, idx_n;
    logic [BASE_W-1:0]  base, base_n;
    logic [BASE_W-1:0]  remain;
    logic [TMR_W-1:0]   timer, timer_n;

    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic               err_q, err_n;
    logic               ram_en_q, ram_en_n;
    logic               ram_write_q, ram_write_n;
    logic [ADDR_W-1:0]  addr_q, addr_n;
    logic [ADDR_W-1:0]  offset_q, offset_n;
    logic [DATA_W-1:0]  wdata_q, wdata_n;
    logic [BLK_W-1:0]   cnn_rd_q, cnn_rd_n;
    logic               fb_write_q, fb_write_n;
    logic               fb_bf_q, fb_bf_n;
    logic [CNT_W-1:0]   fb_index_q, fb_index_n;
    logic [BLK_W-1:0]   fb_data_q, fb_data_n;
    logic [CNT_W-1:0]   fb_valid_q, fb_valid_n;

    // State, transfer context and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            mode_q      <= M_RD;
            inner_addr  <= '0;
            count_q     <= '0;
            idx         <= '0;
            base        <= '0;
            timer       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_write_q <= 1'b0;
            addr_q      <= '0;
            offset_q    <= '0;
            wdata_q     <= '0;
            cnn_rd_q    <= '0;
            fb_write_q  <= 1'b0;
            fb_bf_q     <= 1'b0;
            fb_index_q  <= '0;
            fb_data_q   <= '0;
            fb_valid_q  <= '0;
        end else begin
            state       <= state_n;
            mode_q      <= mode_n;
            inner_addr  <= inner_n;
            count_q     <= count_n;
            idx         <= idx_n;
            base        <= base_n;
            timer       <= timer_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            err_q       <= err_n;
            ram_en_q    <= ram_en_n;
            ram_write_q <= ram_write_n;
            addr_q      <= addr_n;
            offset_q    <= offset_n;
            wdata_q     <= wdata_n;
            cnn_rd_q    <= cnn_rd_n;
            fb_write_q  <= fb_write_n;
            fb_bf_q     <= fb_bf_n;
            fb_index_q  <= fb_index_n;
            fb_data_q   <= fb_data_n;
            fb_valid_q  <= fb_valid_n;
        end
    end

    // Next state, context update and next values of the registered outputs
    always_comb begin
        state_n    = state;
        mode_n     = mode_q;
        inner_n    = inner_addr;
        count_n    = count_q;
        idx_n      = idx;
        base_n     = base;
        timer_n    = timer;
        err_n      = 1'b0;
        addr_n     = addr_q;
        offset_n   = offset_q;
        wdata_n    = wdata_q;
        cnn_rd_n   = cnn_rd_q;
        fb_write_n = 1'b0;
        fb_bf_n    = fb_bf_q;
        fb_index_n = fb_index_q;
        fb_data_n  = fb_data_q;
        fb_valid_n = fb_valid_q;
        remain     = BASE_W'(count_q) - base;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    mode_n   = mode_t'(bus.mode);
                    inner_n  = bus.address;
                    addr_n   = bus.address;
                    offset_n = bus.offset;
                    count_n  = bus.count;
                    wdata_n  = bus.cnn_wr_data;
                    idx_n    = '0;
                    base_n   = '0;
                    timer_n  = '0;
                    // empty filter/bias loads complete without touching RAM
                    if (bus.mode[1] && (bus.count == '0)) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                timer_n = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (bus.ram_finish) begin
                    state_n = S_NEXT;
                    if (mode_q == M_RD) begin
                        cnn_rd_n = bus.ram_rdata;
                    end
                    if ((mode_q == M_FILT) || (mode_q == M_BIAS)) begin
                        fb_write_n = 1'b1;
                        fb_bf_n    = (mode_q == M_FILT);
                        fb_index_n = idx;
                        fb_data_n  = bus.ram_rdata;
                        // only the final bias chunk can be short
                        if ((mode_q == M_FILT) || (remain >= BASE_W'(N))) begin
                            fb_valid_n = CNT_W'(N);
                        end else begin
                            fb_valid_n = CNT_W'(remain);
                        end
                    end
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    state_n = S_DONE;
                    err_n   = 1'b1;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end
            S_NEXT: begin
                state_n = S_DONE;
                idx_n   = idx + CNT_W'(1);
                base_n  = base + BASE_W'(N);
                inner_n = inner_addr + ADDR_W'(N);
                if (((mode_q == M_FILT) && (idx_n != count_q)) ||
                    ((mode_q == M_BIAS) && (base_n < BASE_W'(count_q)))) begin
                    state_n = S_ISSUE;
                    addr_n  = inner_n;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n      = (state_n != S_IDLE);
        done_n      = (state_n == S_DONE);
        ram_en_n    = (state_n == S_ISSUE) || (state_n == S_WAIT);
        ram_write_n = ram_en_n && (mode_n == M_WR);
    end

    // Output drive
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.err               = err_q;
    assign bus.cnn_rd_data       = cnn_rd_q;
    assign bus.ram_en            = ram_en_q;
    assign bus.ram_write         = ram_write_q;
    assign bus.ram_address       = addr_q;
    assign bus.ram_offset        = offset_q;
    assign bus.ram_wdata         = wdata_q;
    assign bus.fb_write          = fb_write_q;
    assign bus.fb_bias_or_filter = fb_bf_q;
    assign bus.fb_index          = fb_index_q;
    assign bus.fb_data           = fb_data_q;
    assign bus.fb_valid          = fb_valid_q;
endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine with a latency-programmable RAM responder.
module tb_dma_engine;
    logic clk;
    logic reset;

    dma_engine_if #(.DATA_W(16), .ADDR_W(16), .WIN(5), .CNT_W(8)) bus ();

    dma_engine #(
        .DATA_W(16), .ADDR_W(16), .WIN(5), .CNT_W(8), .TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc       = 0;
    int issue_cyc = -100;
    int ram_lat   = 3;
    bit ram_hang  = 1'b0;
    logic prev_en = 1'b0;

    int nb = 0;
    int nf = 0;
    int ndone = 0;
    int done_cyc = -1000;
    logic done_err;
    logic [15:0] b_addr [16];
    logic [15:0] b_off  [16];
    logic [15:0] b_we   [16];
    logic [15:0] b_wd   [16];
    logic [15:0] f_idx  [16];
    logic [15:0] f_val  [16];
    logic [15:0] f_bf   [16];
    logic [15:0] f_d0   [16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RAM responder and event recorder, sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (bus.ram_en && !prev_en) begin
            if (nb < 16) begin
                b_addr[nb] = bus.ram_address;
                b_off[nb]  = bus.ram_offset;
                b_we[nb]   = 16'(bus.ram_write);
                b_wd[nb]   = bus.ram_wdata;
            end
            nb = nb + 1;
            issue_cyc = cyc;
        end
        prev_en = bus.ram_en;
        if (bus.ram_en && !ram_hang && (cyc == issue_cyc + ram_lat)) begin
            bus.ram_finish = 1'b1;
            for (int i = 0; i < 25; i++) begin
                bus.ram_rdata[i*16 +: 16] = 16'((nb - 1) * 256 + i + 1);
            end
        end else begin
            bus.ram_finish = 1'b0;
            bus.ram_rdata  = '0;
        end
        if (bus.fb_write) begin
            if (nf < 16) begin
                f_idx[nf] = 16'(bus.fb_index);
                f_val[nf] = 16'(bus.fb_valid);
                f_bf[nf]  = 16'(bus.fb_bias_or_filter);
                f_d0[nf]  = bus.fb_data[15:0];
            end
            nf = nf + 1;
        end
        if (bus.done) begin
            if (ndone == 0) begin
                done_cyc = cyc;
                done_err = bus.err;
            end
            ndone = ndone + 1;
        end
    end

    task automatic clear_rec();
        nb = 0; nf = 0; ndone = 0; done_cyc = -1000; done_err = 1'bx;
        for (int i = 0; i < 16; i++) begin
            b_addr[i] = 'x; b_off[i] = 'x; b_we[i] = 'x; b_wd[i] = 'x;
            f_idx[i]  = 'x; f_val[i] = 'x; f_bf[i] = 'x; f_d0[i] = 'x;
        end
    endtask

    task automatic wait_done(input int s, output int rel);
        int k = 0;
        while (ndone == 0 && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (5) begin @(posedge clk); #1; end
        check("done_once", 64'(ndone), 64'd1);
        check("busy_after", 64'(bus.busy), 64'd0);
        rel = done_cyc - s;
    endtask

    task automatic run(input logic [1:0] m, input logic [15:0] a, input logic [15:0] off,
                       input logic [7:0] c, input logic [15:0] wd, input int lat,
                       input bit hang, output int rel);
        int s;
        clear_rec();
        ram_lat = lat; ram_hang = hang;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode = m; bus.address = a; bus.offset = off;
        bus.count = c; bus.cnn_wr_data = wd;
        s = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(s, rel);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rel;
        int s;
        int k;
        reset = 1'b0;
        bus.start = 1'b0; bus.mode = 2'b00; bus.address = '0; bus.offset = '0;
        bus.count = '0; bus.cnn_wr_data = '0;
        clear_rec();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_en",   64'(bus.ram_en), 64'd0);
        check("rst_busy",     64'(bus.busy), 64'd0);
        check("rst_done",     64'(bus.done), 64'd0);
        check("rst_err",      64'(bus.err), 64'd0);
        check("rst_fb_write", 64'(bus.fb_write), 64'd0);
        check("rst_addr",     64'(bus.ram_address), 64'd0);
        check("rst_fb_valid", 64'(bus.fb_valid), 64'd0);
        check("rst_cnn_w0",   64'(bus.cnn_rd_data[15:0]), 64'd0);
        reset = 1'b1;

        // window read, finish 3 cycles after issue
        run(2'b00, 16'h0100, 16'h0007, 8'd0, 16'h0000, 3, 1'b0, rel);
        check("rd_bursts", 64'(nb), 64'd1);
        check("rd_addr",   64'(b_addr[0]), 64'h0100);
        check("rd_we",     64'(b_we[0]), 64'd0);
        check("rd_off",    64'(b_off[0]), 64'h0007);
        check("rd_w0",     64'(bus.cnn_rd_data[15:0]), 64'd1);
        check("rd_w24",    64'(bus.cnn_rd_data[24*16 +: 16]), 64'd25);
        check("rd_lat",    64'(rel), 64'd6);
        check("rd_err",    64'(done_err), 64'd0);

        // word write
        run(2'b01, 16'h0040, 16'h0000, 8'd0, 16'hBEEF, 3, 1'b0, rel);
        check("wr_bursts", 64'(nb), 64'd1);
        check("wr_we",     64'(b_we[0]), 64'd1);
        check("wr_wdata",  64'(b_wd[0]), 64'hBEEF);
        check("wr_addr",   64'(b_addr[0]), 64'h0040);
        check("wr_no_fb",  64'(nf), 64'd0);
        check("wr_cnn_hold", 64'(bus.cnn_rd_data[15:0]), 64'd1);

        // filter load, three filters
        run(2'b10, 16'h0200, 16'h0010, 8'd3, 16'h0000, 3, 1'b0, rel);
        check("filt_bursts", 64'(nb), 64'd3);
        check("filt_addr0",  64'(b_addr[0]), 64'h0200);
        check("filt_addr1",  64'(b_addr[1]), 64'h0219);
        check("filt_addr2",  64'(b_addr[2]), 64'h0232);
        check("filt_off2",   64'(b_off[2]), 64'h0010);
        check("filt_nfb",    64'(nf), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check("filt_idx", 64'(f_idx[i]), 64'(i));
            check("filt_bf",  64'(f_bf[i]), 64'd1);
        end
        check("filt_valid", 64'(f_val[0]), 64'd25);
        check("filt_d0_1",  64'(f_d0[1]), 64'h0101);
        check("filt_d0_2",  64'(f_d0[2]), 64'h0201);
        check("filt_lat",   64'(rel), 64'd16);
        check("filt_err",   64'(done_err), 64'd0);

        // bias load, 120 words in five chunks
        run(2'b11, 16'h1000, 16'h0000, 8'd120, 16'h0000, 3, 1'b0, rel);
        check("bias_bursts", 64'(nb), 64'd5);
        check("bias_nfb",    64'(nf), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check("bias_idx", 64'(f_idx[i]), 64'(i));
            check("bias_bf",  64'(f_bf[i]), 64'd0);
            check("bias_valid", 64'(f_val[i]), (i == 4) ? 64'd20 : 64'd25);
        end
        check("bias_addr4", 64'(b_addr[4]), 64'h1064);
        check("bias_lat",   64'(rel), 64'd26);

        // empty bias load
        run(2'b11, 16'h2000, 16'h0000, 8'd0, 16'h0000, 3, 1'b0, rel);
        check("zero_bursts", 64'(nb), 64'd0);
        check("zero_lat",    64'(rel), 64'd1);
        check("zero_err",    64'(done_err), 64'd0);

        // timeout on a filter load, with a start pulse while busy
        clear_rec();
        ram_hang = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode = 2'b10; bus.address = 16'h0300; bus.count = 8'd2;
        s = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.mode = 2'b01; bus.address = 16'h0500;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(s, rel);
        check("to_lat",    64'(rel), 64'd18);
        check("to_err",    64'(done_err), 64'd1);
        check("to_no_fb",  64'(nf), 64'd0);
        check("to_bursts", 64'(nb), 64'd1);
        check("to_addr",   64'(b_addr[0]), 64'h0300);
        ram_hang = 1'b0;

        // reset during the second filter burst
        clear_rec();
        ram_lat = 3;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode = 2'b10; bus.address = 16'h0200; bus.count = 8'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 0;
        while (nb < 2 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("mid_burst2_seen", 64'(nb), 64'd2);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("mid_ram_en",   64'(bus.ram_en), 64'd0);
        check("mid_busy",     64'(bus.busy), 64'd0);
        check("mid_fb_write", 64'(bus.fb_write), 64'd0);
        check("mid_addr",     64'(bus.ram_address), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_no_done",  64'(ndone), 64'd0);
        check("mid_nfb",      64'(nf), 64'd1);
        reset = 1'b1;

        run(2'b10, 16'h0300, 16'h0000, 8'd2, 16'h0000, 3, 1'b0, rel);
        check("post_nfb",   64'(nf), 64'd2);
        check("post_idx0",  64'(f_idx[0]), 64'd0);
        check("post_idx1",  64'(f_idx[1]), 64'd1);
        check("post_addr1", 64'(b_addr[1]), 64'h0319);
        check("post_lat",   64'(rel), 64'd11);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
